// File: rtl/alu_mdu_if.sv
// Execute-stage ALU/MDU bus: request/operands from the pipeline, results and status back.
interface alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       control;
  logic [WIDTH-1:0] read1;
  logic [WIDTH-1:0] foutput;
  logic [WIDTH-1:0] out;
  logic             overflow;
  logic             zero;
  logic             busy;
  logic             done;
  logic             divzero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, control, read1, foutput,
    input  out, overflow, zero, busy, done, divzero, hi, lo
  );

  modport slave (
    input  start, control, read1, foutput,
    output out, overflow, zero, busy, done, divzero, hi, lo
  );
endinterface

// File: rtl/alu_mdu.sv
// Registered ALU with an iterative multiply/divide unit writing HI/LO.
// Single-cycle ops go through a one-stage operand pipeline; mult/div run one bit per cycle.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     reset,
  alu_mdu_if.slave bus
);

  localparam logic [5:0] OP_SLLV  = 6'd4;
  localparam logic [5:0] OP_SRLV  = 6'd6;
  localparam logic [5:0] OP_SRAV  = 6'd7;
  localparam logic [5:0] OP_ADD   = 6'd16;
  localparam logic [5:0] OP_MFLO  = 6'd18;
  localparam logic [5:0] OP_MFHI  = 6'd20;
  localparam logic [5:0] OP_MULT  = 6'd24;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_DIV   = 6'd26;
  localparam logic [5:0] OP_DIVU  = 6'd27;
  localparam logic [5:0] OP_ADDU  = 6'd33;
  localparam logic [5:0] OP_SUB   = 6'd34;
  localparam logic [5:0] OP_OR    = 6'd35;
  localparam logic [5:0] OP_AND   = 6'd36;
  localparam logic [5:0] OP_SUBU  = 6'd37;
  localparam logic [5:0] OP_NOR   = 6'd39;
  localparam logic [5:0] OP_SLT   = 6'd42;
  localparam logic [5:0] OP_SLTU  = 6'd43;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t state, state_nxt;

  logic             accept, is_mdu, is_signed_mdu;
  logic             sc_valid;
  logic [5:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] out_r, hi_r, lo_r;
  logic             ovf_r, done_r, divzero_r;

  // MDU working registers: acc is the running high half / partial remainder,
  // qr the multiplier shifting out / quotient shifting in, dvs the multiplicand or divisor.
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc, qr, dvs;
  logic             div_op, neg_q, neg_r;

  logic [WIDTH-1:0] res;
  logic             res_ovf;
  logic [WIDTH-1:0] sum, diff;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] prod_mag;

  assign is_mdu        = bus.control inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  assign is_signed_mdu = (bus.control == OP_MULT) || (bus.control == OP_DIV);
  assign accept        = bus.start && (state == S_IDLE);

  assign a_neg = is_signed_mdu && bus.read1[WIDTH-1];
  assign b_neg = is_signed_mdu && bus.foutput[WIDTH-1];
  assign a_mag = a_neg ? -bus.read1   : bus.read1;
  assign b_mag = b_neg ? -bus.foutput : bus.foutput;

  assign mul_sum   = {1'b0, acc} + (qr[0] ? {1'b0, dvs} : '0);
  assign div_shift = {acc, qr[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, dvs};
  assign prod_mag  = {acc, qr};

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;

  // NOTE: every signal written in always_comb gets a default first so no path infers a latch.
  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    case (op_q)
      OP_AND:  res = a_q & b_q;
      OP_OR:   res = a_q | b_q;
      OP_NOR:  res = ~(a_q | b_q);
      OP_ADD: begin
        res     = sum;
        res_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res     = diff;
        res_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_ADDU: res = sum;
      OP_SUBU: res = diff;
      OP_SLT:  res[0] = $signed(a_q) < $signed(b_q);
      OP_SLTU: res[0] = a_q < b_q;
      OP_SLLV: res = b_q << a_q[SHW-1:0];
      OP_SRLV: res = b_q >> a_q[SHW-1:0];
      OP_SRAV: res = $signed(b_q) >>> a_q[SHW-1:0];
      OP_MFHI: res = hi_r;
      OP_MFLO: res = lo_r;
      default: res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && is_mdu)
                state_nxt = (bus.control == OP_MULT || bus.control == OP_MULTU) ? S_MUL : S_DIV;
      S_MUL,
      S_DIV:  if (cnt == SHW'(WIDTH - 1)) state_nxt = S_FIN;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sc_valid  <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      out_r     <= '0;
      ovf_r     <= 1'b0;
      done_r    <= 1'b0;
      divzero_r <= 1'b0;
      hi_r      <= '0;
      lo_r      <= '0;
      cnt       <= '0;
      acc       <= '0;
      qr        <= '0;
      dvs       <= '0;
      div_op    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      sc_valid <= accept && !is_mdu;
      done_r   <= sc_valid || (state == S_FIN);

      if (accept) begin
        op_q <= bus.control;
        a_q  <= bus.read1;
        b_q  <= bus.foutput;
      end

      if (sc_valid) begin
        out_r <= res;
        ovf_r <= res_ovf;
      end

      case (state)
        S_IDLE: if (accept && is_mdu) begin
          div_op <= (bus.control == OP_DIV) || (bus.control == OP_DIVU);
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          cnt    <= '0;
          acc    <= '0;
          // Multiply shifts the B magnitude out of qr; divide shifts the A magnitude out as quotient bits enter.
          if (bus.control == OP_MULT || bus.control == OP_MULTU) begin
            qr  <= b_mag;
            dvs <= a_mag;
          end else begin
            qr  <= a_mag;
            dvs <= b_mag;
          end
        end
        S_MUL: begin
          acc <= mul_sum[WIDTH:1];
          qr  <= {mul_sum[0], qr[WIDTH-1:1]};
          cnt <= cnt + SHW'(1);
        end
        S_DIV: begin
          if (!div_trial[WIDTH]) begin
            acc <= div_trial[WIDTH-1:0];
            qr  <= {qr[WIDTH-2:0], 1'b1};
          end else begin
            acc <= div_shift[WIDTH-1:0];
            qr  <= {qr[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + SHW'(1);
        end
        S_FIN: begin
          if (div_op) begin
            if (dvs == '0) begin
              lo_r      <= '1;
              hi_r      <= a_q;
              divzero_r <= 1'b1;
            end else begin
              lo_r      <= neg_q ? -qr  : qr;
              hi_r      <= neg_r ? -acc : acc;
              divzero_r <= 1'b0;
            end
          end else begin
            {hi_r, lo_r} <= neg_q ? -prod_mag : prod_mag;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out      = out_r;
  assign bus.overflow = ovf_r;
  assign bus.zero     = (out_r == '0);
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = done_r;
  assign bus.divzero  = divzero_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;

endmodule

// File: tb/tb_alu_mdu.sv
// Randomised and directed bench for alu_mdu against an arithmetic reference model.
module tb_alu_mdu;

  localparam int W = 32;

  localparam logic [5:0] C_SLLV = 6'd4,  C_SRLV = 6'd6,  C_SRAV = 6'd7,  C_ADD  = 6'd16;
  localparam logic [5:0] C_MFLO = 6'd18, C_MFHI = 6'd20, C_MULT = 6'd24, C_MULTU = 6'd25;
  localparam logic [5:0] C_DIV  = 6'd26, C_DIVU = 6'd27, C_ADDU = 6'd33, C_SUB  = 6'd34;
  localparam logic [5:0] C_OR   = 6'd35, C_AND  = 6'd36, C_SUBU = 6'd37, C_NOR  = 6'd39;
  localparam logic [5:0] C_SLT  = 6'd42, C_SLTU = 6'd43;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_mdu_if #(.WIDTH(W)) bus ();
  alu_mdu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_out = '0, m_hi = '0, m_lo = '0;
  logic         m_dz  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_single(input logic [5:0] c, input logic [W-1:0] a, b,
                                       output logic [W-1:0] r, output logic o);
    longint sa, sb, s;
    sa = $signed(a);
    sb = $signed(b);
    r = '0;
    o = 1'b0;
    case (c)
      C_AND:  r = a & b;
      C_OR:   r = a | b;
      C_NOR:  r = ~(a | b);
      C_ADD:  begin s = sa + sb; r = s[W-1:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      C_SUB:  begin s = sa - sb; r = s[W-1:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      C_ADDU: r = a + b;
      C_SUBU: r = a - b;
      C_SLT:  r = (sa < sb) ? 1 : 0;
      C_SLTU: r = (a < b) ? 1 : 0;
      C_SLLV: r = b << a[4:0];
      C_SRLV: r = b >> a[4:0];
      C_SRAV: r = $signed(b) >>> a[4:0];
      C_MFHI: r = m_hi;
      C_MFLO: r = m_lo;
      default: r = '0;
    endcase
  endfunction

  function automatic void model_mdu(input logic [5:0] c, input logic [W-1:0] a, b);
    longint sa, sb, q, rm;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (c)
      C_MULT:  begin p = sa * sb; {m_hi, m_lo} = p; end
      C_MULTU: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
      default: begin
        if (b == 0) begin
          m_lo = '1; m_hi = a; m_dz = 1'b1;
        end else begin
          if (c == C_DIV) begin q = sa / sb; rm = sa % sb; end
          else            begin q = a / b;   rm = a % b;   end
          m_lo = q[W-1:0]; m_hi = rm[W-1:0]; m_dz = 1'b0;
        end
      end
    endcase
  endfunction

  function automatic bit is_mdu_op(input logic [5:0] c);
    return c inside {C_MULT, C_MULTU, C_DIV, C_DIVU};
  endfunction

  // Present a request for one edge, then scramble operands to prove they were latched.
  task automatic issue(input logic [5:0] c, input logic [W-1:0] a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.control = c; bus.read1 = a; bus.foutput = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.read1 = $urandom; bus.foutput = $urandom;
  endtask

  task automatic run_single(input logic [5:0] c, input logic [W-1:0] a, b);
    logic [W-1:0] er;
    logic eo;
    model_single(c, a, b, er, eo);
    issue(c, a, b);
    check("sc_busy", bus.busy, 0);
    @(posedge clk); #1;
    check($sformatf("op%0d_out", c), bus.out, er);
    check($sformatf("op%0d_ovf", c), bus.overflow, eo);
    check($sformatf("op%0d_zero", c), bus.zero, er == 0);
    check($sformatf("op%0d_done", c), bus.done, 1);
    m_out = er;
  endtask

  task automatic run_mdu(input logic [5:0] c, input logic [W-1:0] a, b);
    int lat = 0;
    model_mdu(c, a, b);
    issue(c, a, b);
    check("mdu_busy", bus.busy, 1);
    for (int i = 1; i <= W + 8; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = i; break; end
    end
    check($sformatf("op%0d_latency", c), lat, W + 1);
    check($sformatf("op%0d_hi", c), bus.hi, m_hi);
    check($sformatf("op%0d_lo", c), bus.lo, m_lo);
    check($sformatf("op%0d_divzero", c), bus.divzero, m_dz);
    check($sformatf("op%0d_out_kept", c), bus.out, m_out);
    check($sformatf("op%0d_busy_end", c), bus.busy, 0);
    @(posedge clk); #1;
    check($sformatf("op%0d_done_pulse", c), bus.done, 0);
  endtask

  task automatic run_op(input logic [5:0] c, input logic [W-1:0] a, b);
    if (is_mdu_op(c)) run_mdu(c, a, b);
    else              run_single(c, a, b);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] op_list [21] = '{C_AND, C_OR, C_NOR, C_ADD, C_SUB, C_ADDU, C_SUBU, C_SLT, C_SLTU,
                               C_SLLV, C_SRLV, C_SRAV, C_MFHI, C_MFLO, C_MULT, C_MULTU,
                               C_DIV, C_DIVU, 6'd0, 6'd63, 6'd1};

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn, at;
    logic [W-1:0] r1, r2;
    logic o1;

    bus.start = 1'b0; bus.control = '0; bus.read1 = '0; bus.foutput = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", bus.out, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_zero", bus.zero, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_divzero", bus.divzero, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    @(negedge clk);
    reset = 1'b0;

    run_op(C_ADD, 32'h7FFF_FFFF, 32'd1);
    check("tp_add_out", bus.out, 32'h8000_0000);
    check("tp_add_ovf", bus.overflow, 1);
    run_op(C_ADDU, 32'h7FFF_FFFF, 32'd1);
    check("tp_addu_ovf", bus.overflow, 0);
    run_op(C_SUB, 32'h8000_0000, 32'd1);
    check("tp_sub_out", bus.out, 32'h7FFF_FFFF);
    check("tp_sub_ovf", bus.overflow, 1);
    run_op(C_SLT, 32'hFFFF_FFFF, 32'd1);
    check("tp_slt", bus.out, 1);
    run_op(C_SLTU, 32'hFFFF_FFFF, 32'd1);
    check("tp_sltu", bus.out, 0);
    run_op(C_SRAV, 32'd4, 32'h8000_0000);
    check("tp_srav", bus.out, 32'hF800_0000);
    run_op(C_MULT, -32'sd3, 32'd7);
    check("tp_mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("tp_mult_lo", bus.lo, 32'hFFFF_FFEB);
    run_op(C_MFLO, 32'd0, 32'd0);
    check("tp_mflo", bus.out, 32'hFFFF_FFEB);
    run_op(C_DIV, -32'sd7, 32'd2);
    check("tp_div_lo", bus.lo, 32'hFFFF_FFFD);
    check("tp_div_hi", bus.hi, 32'hFFFF_FFFF);
    run_op(C_DIVU, 32'd7, 32'd0);
    check("tp_div0_lo", bus.lo, 32'hFFFF_FFFF);
    check("tp_div0_hi", bus.hi, 32'd7);
    check("tp_div0_flag", bus.divzero, 1);
    run_op(C_MULTU, 32'd5, 32'd5);
    check("tp_mult_keeps_dz", bus.divzero, 1);
    run_op(C_DIVU, 32'd9, 32'd3);
    check("tp_divu_dz", bus.divzero, 0);
    check("tp_divu_lo", bus.lo, 32'd3);
    check("tp_divu_hi", bus.hi, 32'd0);
    run_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("tp_minneg_lo", bus.lo, 32'h8000_0000);
    check("tp_minneg_hi", bus.hi, 32'd0);
    check("tp_minneg_dz", bus.divzero, 0);
    run_op(C_MFHI, 32'd0, 32'd0);

    // Back-to-back single-cycle ops complete on consecutive cycles.
    model_single(C_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, r1, o1);
    model_single(C_NOR, 32'h0000_00FF, 32'h0F00_0000, r2, o1);
    issue(C_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
    issue(C_NOR, 32'h0000_00FF, 32'h0F00_0000);
    check("b2b_out1", bus.out, r1);
    check("b2b_done1", bus.done, 1);
    @(posedge clk); #1;
    check("b2b_out2", bus.out, r2);
    check("b2b_done2", bus.done, 1);
    m_out = r2;
    @(posedge clk); #1;
    check("b2b_done_end", bus.done, 0);

    for (int n = 0; n < 60; n++)
      run_op(op_list[$urandom_range(0, 20)], rand_operand(), rand_operand());

    // Starts while busy, including the FIN edge, must be ignored.
    model_mdu(C_MULT, -32'sd3, 32'd7);
    issue(C_MULT, -32'sd3, 32'd7);
    dn = 0; at = 0;
    for (int i = 1; i <= W + 6; i++) begin
      @(negedge clk);
      bus.start = (i == 5) || (i == W + 1);
      bus.control = C_AND; bus.read1 = 32'hFFFF_FFFF; bus.foutput = 32'h0F0F_0F0F;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin dn++; at = i; end
    end
    check("hs_done_count", dn, 1);
    check("hs_done_edge", at, W + 1);
    check("hs_out_kept", bus.out, m_out);
    check("hs_hi", bus.hi, m_hi);
    check("hs_lo", bus.lo, m_lo);

    // Reset ten edges into a divide aborts it without a done pulse.
    issue(C_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rmid_busy", bus.busy, 0);
    check("rmid_hi", bus.hi, 0);
    check("rmid_lo", bus.lo, 0);
    check("rmid_done", bus.done, 0);
    m_out = '0; m_hi = '0; m_lo = '0; m_dz = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    check("rmid_no_done", dn, 0);
    check("rmid_busy_after", bus.busy, 0);
    run_op(C_ADD, 32'd5, 32'd6);
    check("rmid_add", bus.out, 32'd11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
